// File: rtl/serial_echo_ctrl_pkg.sv
// Shared definitions for the serial echo sequencer: transform mode codes, FSM
// state encodings, parameter defaults and the byte transform helper.
package serial_echo_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_ADD  = 2'b01,
    MODE_INV  = 2'b10,
    MODE_DROP = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_XFORM = 2'b01,
    S_PUSH  = 2'b10
  } state_e;

  localparam logic [7:0] DEFAULT_ERR_CODE  = 8'hEE;
  localparam logic [7:0] DEFAULT_INCREMENT = 8'h01;

  // MODE_DROP returns the byte unchanged; the caller decides not to queue it.
  function automatic logic [7:0] transform_byte(input mode_e m, input logic [7:0] d,
                                                input logic [7:0] inc);
    case (m)
      MODE_ADD: transform_byte = d + inc;
      MODE_INV: transform_byte = ~d;
      default:  transform_byte = d;
    endcase
  endfunction

endpackage

// File: rtl/serial_echo_ctrl_if.sv
// Byte handshake bundle between the RS232 receiver/transmitter and the echo sequencer.
// The sequencer is the slave: it consumes RX bytes and offers TX bytes.
interface serial_echo_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_err, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_err, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/serial_echo_ctrl_queue.sv
// Synchronous FIFO holding bytes waiting for the transmitter. Head is shown
// combinationally; push and pop in one cycle are both honoured, even when full.
module serial_echo_ctrl_queue #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count_next
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head reads as zero when empty so tx_data never shows stale or unwritten entries.
  assign head_data = empty ? '0 : mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Pointers are PTR_W bits wide, so a power-of-two depth wraps them naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

endmodule

// File: rtl/serial_echo_ctrl.sv
// Echo sequencer: pops one RX byte at a time, transforms it (or substitutes an
// error code), queues it for TX, drives cts from queue occupancy and counts bytes.
module serial_echo_ctrl
  import serial_echo_ctrl_pkg::*;
#(
  parameter logic [7:0] INCREMENT   = DEFAULT_INCREMENT,
  parameter logic [7:0] ERR_CODE    = DEFAULT_ERR_CODE,
  parameter bit         REPORT_ERR  = 1'b1,
  parameter int         QUEUE_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [1:0]         mode,
  serial_echo_ctrl_if.slave  bus,
  output logic               cts,
  output logic [15:0]        echo_count,
  output logic [15:0]        err_count
);

  localparam int               CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CTS_MAX = CNT_W'(QUEUE_DEPTH - 2);

  state_e           state_reg;
  state_e           state_next;
  logic [7:0]       byte_reg;
  logic             err_reg;
  mode_e            mode_reg;
  logic [7:0]       result_reg;
  logic             push_reg;
  logic             cts_reg;
  logic [15:0]      echo_count_reg;
  logic [15:0]      err_count_reg;

  logic             rx_ready_comb;
  logic             rx_fire;
  logic             q_push;
  logic             q_pop;
  logic             q_full;
  logic             q_empty;
  logic [7:0]       q_head;
  logic [CNT_W-1:0] q_count_next;

  assign rx_fire = bus.rx_valid & rx_ready_comb;
  assign q_pop   = ~q_empty & bus.tx_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (rx_fire) state_next = S_XFORM;
      S_XFORM: state_next = S_PUSH;
      S_PUSH:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic; rx_ready is held low while reset is asserted, whatever enable says.
  always_comb begin
    rx_ready_comb = 1'b0;
    q_push        = 1'b0;
    case (state_reg)
      S_IDLE:  rx_ready_comb = rst_n & enable & ~q_full;
      S_PUSH:  q_push = push_reg;
      default: ;
    endcase
  end

  // Mode is captured with the byte so a mid-byte change only affects the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_reg       <= '0;
      err_reg        <= 1'b0;
      mode_reg       <= MODE_PASS;
      result_reg     <= '0;
      push_reg       <= 1'b0;
      echo_count_reg <= '0;
      err_count_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (rx_fire) begin
            byte_reg <= bus.rx_data;
            err_reg  <= bus.rx_err;
            mode_reg <= mode_e'(mode);
          end
        end
        S_XFORM: begin
          if (err_reg) begin
            result_reg    <= ERR_CODE;
            push_reg      <= REPORT_ERR;
            err_count_reg <= err_count_reg + 16'd1;
          end else begin
            result_reg <= transform_byte(mode_reg, byte_reg, INCREMENT);
            push_reg   <= (mode_reg != MODE_DROP);
          end
        end
        S_PUSH: begin
          if (push_reg && !err_reg) begin
            echo_count_reg <= echo_count_reg + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // cts follows the count the queue will hold after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_reg <= 1'b1;
    end else begin
      cts_reg <= (q_count_next <= CTS_MAX);
    end
  end

  serial_echo_ctrl_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (8)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (q_push),
    .push_data  (result_reg),
    .pop        (q_pop),
    .head_data  (q_head),
    .full       (q_full),
    .empty      (q_empty),
    .count_next (q_count_next)
  );

  assign bus.rx_ready = rx_ready_comb;
  assign bus.tx_data  = q_head;
  assign bus.tx_valid = ~q_empty;
  assign cts          = cts_reg;
  assign echo_count   = echo_count_reg;
  assign err_count    = err_count_reg;

endmodule

// File: tb/tb_serial_echo_ctrl.sv
// Self-checking bench for serial_echo_ctrl: directed scenarios plus a randomized
// phase, checked against an ordered byte-stream model with expected counters.
module tb_serial_echo_ctrl;
  import serial_echo_ctrl_pkg::*;

  localparam logic [7:0] INC  = 8'h01;
  localparam logic [7:0] ERRC = 8'hEE;
  localparam bit         REP  = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        cts;
  logic [15:0] echo_count;
  logic [15:0] err_count;

  serial_echo_ctrl_if bus();

  serial_echo_ctrl #(
    .INCREMENT   (INC),
    .ERR_CODE    (ERRC),
    .REPORT_ERR  (REP),
    .QUEUE_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .bus        (bus),
    .cts        (cts),
    .echo_count (echo_count),
    .err_count  (err_count)
  );

  always #10 clk = ~clk;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [7:0]  exp_q[$];
  int unsigned exp_echo = 0;
  int unsigned exp_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: what one accepted RX byte must eventually produce on TX.
  function automatic void model_accept(input logic [7:0] d, input logic e, input logic [1:0] m);
    logic [7:0] r;
    if (e) begin
      exp_err++;
      if (REP) exp_q.push_back(ERRC);
    end else if (m != 2'b11) begin
      case (m)
        2'b01:   r = 8'((int'(d) + int'(INC)) % 256);
        2'b10:   r = 8'(255 - int'(d));
        default: r = d;
      endcase
      exp_q.push_back(r);
      exp_echo++;
    end
  endfunction

  // Transfers are decided at the next rising edge; observe them mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_valid && bus.rx_ready) model_accept(bus.rx_data, bus.rx_err, mode);
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) check("tx_spurious", 32'(bus.tx_valid), 32'd0);
        else check("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs();
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus.rx_ready) break;
      n++;
    end
    check("hs_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic e);
    bus.rx_data  = d;
    bus.rx_err   = e;
    bus.rx_valid = 1'b1;
    wait_hs();
  endtask

  task automatic drain();
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 60 && (exp_q.size() != 0 || bus.tx_valid); i++) tick();
    repeat (4) tick();
    check("drain_empty", 32'(bus.tx_valid), 32'd0);
    check("drain_model", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({tag, "_cts"}, 32'(cts), 32'd1);
    check({tag, "_echo"}, 32'(echo_count), 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_err   = 1'b0;
    bus.tx_ready = 1'b0;
    enable       = 1'b1;
    rst_n        = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // enable low: nothing is fetched
    enable = 1'b0;
    bus.rx_data = 8'h11;
    bus.rx_valid = 1'b1;
    repeat (4) tick();
    check("en_off_ready", 32'(bus.rx_ready), 32'd0);
    bus.rx_valid = 1'b0;
    enable = 1'b1;

    // add mode and handshake-to-tx_valid latency
    bus.tx_ready = 1'b1;
    mode = 2'b01;
    send(8'h53, 1'b0);
    tick();
    check("lat_early", 32'(bus.tx_valid), 32'd0);
    tick();
    check("lat_valid", 32'(bus.tx_valid), 32'd1);
    check("lat_data", 32'(bus.tx_data), 32'h54);
    drain();
    check("echo_after_1", 32'(echo_count), 32'd1);

    // wrap, invert, discard
    mode = 2'b01; send(8'hFF, 1'b0);
    mode = 2'b10; send(8'h0F, 1'b0);
    drain();
    mode = 2'b11; send(8'h12, 1'b0);
    repeat (4) tick();
    check("drop_no_tx", 32'(bus.tx_valid), 32'd0);
    check("echo_after_drop", 32'(echo_count), 32'd3);

    // errored byte becomes the error code
    mode = 2'b00;
    send(8'h53, 1'b1);
    drain();
    check("err_count_1", 32'(err_count), 32'd1);
    check("echo_unchanged", 32'(echo_count), 32'd3);

    // back-pressure: fill queue, cts and rx_ready throttle
    bus.tx_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(8'hA0 + 8'(k), 1'b0);
      repeat (3) tick();
      if (k == 1) check("cts_at2", 32'(cts), 32'd1);
      if (k == 2) check("cts_at3", 32'(cts), 32'd0);
      if (k == 3) check("full_ready", 32'(bus.rx_ready), 32'd0);
    end
    check("head_hold", 32'(bus.tx_data), 32'hA0);
    bus.rx_data = 8'hA4;
    bus.rx_err = 1'b0;
    bus.rx_valid = 1'b1;
    repeat (5) tick();
    check("fifth_held", 32'(bus.rx_ready), 32'd0);
    check("cts_full", 32'(cts), 32'd0);
    bus.tx_ready = 1'b1;
    wait_hs();
    drain();
    check("cts_back", 32'(cts), 32'd1);

    // randomized traffic with concurrent push/pop and enable toggling
    for (int c = 0; c < 600; c++) begin
      bus.rx_valid = 1'($urandom_range(0, 1));
      bus.rx_data  = 8'($urandom);
      bus.rx_err   = ($urandom_range(0, 7) == 0);
      mode         = 2'($urandom);
      enable       = ($urandom_range(0, 7) != 0);
      bus.tx_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    enable = 1'b1;
    drain();
    check("rand_echo", 32'(echo_count), 32'(exp_echo & 32'hFFFF));
    check("rand_err", 32'(err_count), 32'(exp_err & 32'hFFFF));
    check("rand_cts", 32'(cts), 32'd1);

    // reset while a byte is being transformed
    bus.tx_ready = 1'b0;
    mode = 2'b00;
    send(8'h31, 1'b0);
    repeat (3) tick();
    send(8'h32, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_echo = 0;
    exp_err = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    mode = 2'b01;
    bus.tx_ready = 1'b1;
    send(8'h41, 1'b0);
    drain();
    check("post_reset_echo", 32'(echo_count), 32'd1);
    check("post_reset_err", 32'(err_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
